// File: rtl/mult_seq_ctrl.sv
// Iterative 32-step shift-add multiplier controller for MULT/MULTU.
// Commits the full 2*WIDTH-bit product to hi/lo and stalls the pipeline while busy.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_valid,
  input  logic             mult_signed,
  input  logic [WIDTH-1:0] mult_op1,
  input  logic [WIDTH-1:0] mult_op2,
  input  logic             mult_cancel,
  output logic             mult_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    prod;

  // Magnitudes as unsigned values, so the most negative operand stays representable.
  assign mag1 = (mult_signed && mult_op1[WIDTH-1]) ? (~mult_op1 + 1'b1) : mult_op1;
  assign mag2 = (mult_signed && mult_op2[WIDTH-1]) ? (~mult_op2 + 1'b1) : mult_op2;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? (~acc_step + 1'b1) : acc_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (mult_valid) begin
          state_d  = StCalc;
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StCalc: begin
        if (mult_cancel) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            hi_d    = prod[PW-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mult_ready   = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_mult_seq_ctrl;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mult_valid = 1'b0;
  logic          mult_signed = 1'b0;
  logic [W-1:0]  mult_op1 = '0;
  logic [W-1:0]  mult_op2 = '0;
  logic          mult_cancel = 1'b0;
  logic          mult_ready, busy, result_valid;
  logic [W-1:0]  hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .mult_valid   (mult_valid),
    .mult_signed  (mult_signed),
    .mult_op1     (mult_op1),
    .mult_op2     (mult_op2),
    .mult_cancel  (mult_cancel),
    .mult_ready   (mult_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Reference model: phase 0 = idle, 1..W = compute cycles, W+1 = result cycle.
  int          m_phase = 0;
  logic [63:0] m_prod = '0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_known <= 1'b1;
    end else if (m_phase == 0) begin
      if (mult_valid) begin
        m_phase <= 1;
        m_prod  <= ref_prod(mult_op1, mult_op2, mult_signed);
      end
    end else if (m_phase <= W) begin
      if (mult_cancel) m_phase <= 0;
      else if (m_phase == W) begin
        m_phase <= W + 1;
        m_hi    <= m_prod[63:32];
        m_lo    <= m_prod[31:0];
      end else m_phase <= m_phase + 1;
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_ready", 64'(mult_ready), 64'(m_phase == 0));
      check("model_busy", 64'(busy), 64'(m_phase != 0));
      check("model_rvalid", 64'(result_valid), 64'(m_phase == W + 1));
      check("model_hi", 64'(hi), 64'(m_hi));
      check("model_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mult_ready) return;
    end
    check("wait_idle_timeout", 64'(mult_ready), 64'd1);
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int cyc = 0;
    int bcnt = 0;
    bit got = 0;
    wait_idle();
    @(posedge clk); #1;
    mult_valid = 1'b1; mult_op1 = a; mult_op2 = b; mult_signed = s;
    @(posedge clk); #1;
    mult_valid = 1'b0; mult_op1 = $urandom; mult_op2 = $urandom;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (result_valid) got = 1;
    end
    check("latency", 64'(cyc), 64'd33);
    check("busy_cycles", 64'(bcnt), 64'd33);
    check("lit_hi", 64'(hi), 64'(exp_hi));
    check("lit_lo", 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check("ready_after", 64'(mult_ready), 64'd1);
  endtask

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    int pulses;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(mult_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rvalid", 64'(result_valid), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    run_mult(32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    run_mult(32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mult(32'd5, 32'd6, 1'b0, 32'd0, 32'd30);

    // Cancel in the tenth compute cycle.
    wait_idle();
    @(posedge clk); #1;
    mult_valid = 1'b1; mult_op1 = 32'd9; mult_op2 = 32'd9; mult_signed = 1'b0;
    @(posedge clk); #1;
    mult_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 mult_cancel = 1'b1;
    @(posedge clk); #1;
    mult_cancel = 1'b0;
    @(negedge clk);
    check("cancel_ready", 64'(mult_ready), 64'd1);
    check("cancel_busy", 64'(busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("cancel_no_pulse", 64'(pulses), 64'd0);
    check("cancel_hi", 64'(hi), 64'd0);
    check("cancel_lo", 64'(lo), 64'd30);

    // Valid held high with operands changing every cycle.
    @(posedge clk); #1;
    mult_valid = 1'b1; mult_op1 = 32'hFFFF_FFFE; mult_op2 = 32'd7; mult_signed = 1'b1;
    @(posedge clk);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      #1 mult_op1 = $urandom; mult_op2 = $urandom; mult_signed = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (result_valid) break;
      @(posedge clk);
    end
    check("held_latency", 64'(cyc), 64'd33);
    check("held_hi", 64'(hi), 64'hFFFF_FFFF);
    check("held_lo", 64'(lo), 64'hFFFF_FFF2);
    @(negedge clk);
    check("held_idle_gap", 64'(mult_ready), 64'd1);
    @(negedge clk);
    check("held_reaccept", 64'(busy), 64'd1);
    #1 mult_valid = 1'b0;

    // Reset during compute.
    wait_idle();
    @(posedge clk); #1;
    mult_valid = 1'b1; mult_op1 = 32'd9; mult_op2 = 32'd9; mult_signed = 1'b0;
    @(posedge clk); #1;
    mult_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_rvalid", 64'(result_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(mult_ready), 64'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      mult_valid  = ($urandom_range(0, 3) != 0);
      mult_signed = 1'($urandom);
      mult_op1    = pick_op();
      mult_op2    = pick_op();
      mult_cancel = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    mult_valid = 1'b0; mult_cancel = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
